n_adder: RTL and testbench
==========================

# n_adder

Parameterised N-bit two's-complement/unsigned adder with carry-in, producing sum, carry-out and signed-overflow flags. It serves as the arithmetic core for the ALU's add/subtract datapath. Subtraction is done by the caller inverting `in2` and setting `Cin`. Results are registered once, so the block presents a fixed one-cycle latency to the pipeline.

## Interface
- `N`, default 32: operand and result width in bits; legal values are N ≥ 2.
- `clk` input 1: system clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset; clears all output registers immediately.
- `in1` input N: operand A, unsigned or two's-complement.
- `in2` input N: operand B, unsigned or two's-complement.
- `Cin` input 1: carry into bit 0.
- `result` output N: registered (in1 + in2 + Cin) mod 2^N.
- `Cout` output 1: registered carry out of bit N-1 (unsigned overflow / ARM C flag).
- `Vout` output 1: registered signed overflow (ARM V flag).

## Operation
- Combinational sum S = in1 + in2 + Cin, computed to N+1 bits. `result` = S[N-1:0] and `Cout` = S[N].
- `Vout` = carry into bit N-1 XOR carry out of bit N-1.
  - Equivalent definition: the operand MSBs are equal and the result MSB differs from them.
- Carry chain:
  - 4-bit carry-lookahead groups with per-bit generate g = a&b and propagate p = a^b.
  - Group carries ripple from one group to the next.
  - If N is not a multiple of 4, the top group is narrower; its unused lanes are tied off with p = 0 and g = 0.
- No saturation, sign extension or flag masking: the adder wraps modulo 2^N.
- There are no enable or valid inputs. Every cycle captures the current inputs.

## Timing
- Latency is 1 cycle. Inputs sampled at rising edge k appear on `result`, `Cout` and `Vout` after edge k (during cycle k+1).
- Throughput is one addition per cycle. Back-to-back operand changes each produce their own result one cycle later.
- Reset:
  - While `rst` = 1, `result` = 0, `Cout` = 0 and `Vout` = 0, regardless of `clk`.
  - Assertion takes effect without waiting for a clock edge.
- First result after reset: the first rising edge with `rst` = 0 loads the sum of the inputs present at that edge.
- Reset asserted mid-stream discards the in-flight result. No partial or stale value is ever output after reset.
- The critical path is the full group carry chain and must close timing within a single cycle at N = 32.

## Structure
- Sub-module `cla4`:
  - Inputs: 4-bit a, 4-bit b, ci.
  - Outputs: 4-bit s, co, and c3, the carry into its bit 3, used for `Vout` in the top group.
- The top level instantiates ceil(N/4) `cla4` groups via a generate loop, then the output register stage.
- Shared package `adder_pkg` holds the group width constant (4) and the default width (32), for ALU reuse.
- No typedefs are required.

## Test plan
- N = 32, Cin = 0: 2+3 → result 5, C = 0, V = 0; 1+3 → 4, C = 0, V = 0.
- 14+1 → 15 and 15+1 → 16, both with C = 0, V = 0; covers a carry crossing the 4-bit group boundary.
- 0x7FFFFFFF+1 → 0x80000000, C = 0, V = 1 (positive overflow).
- 0xFFFFFFFF+1 → 0x00000000, C = 1, V = 0.
- 0x80000000+0x80000000 → 0, C = 1, V = 1 (negative overflow).
- Cin = 1:
  - 0xFFFFFFFF+0 → 0, C = 1, V = 0.
  - 5 + ~3 → 2, C = 1, V = 0 (subtract 5−3).
- Latency and reset:
  - Apply operands every cycle; check each result appears exactly one edge later.
  - Assert `rst` asynchronously between edges; check outputs go to 0 before the next edge and stay 0 until the first edge after release.
  - Repeat the arithmetic checks with N = 8, where 127+1 → 0x80 with V = 1.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared adder constants for the ALU datapath
package adder_pkg;
   localparam int GW        = 4;
   localparam int DEFAULT_N = 32;
endpackage

// File: rtl/cla4.sv
// rtl/cla4.sv - 4-bit carry-lookahead group with carry into bit 3 exposed
module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co,
   output logic       c3
);
   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // Lookahead equations flattened so no carry ripples inside the group.
   assign c[0] = ci;
   assign c[1] = g[0] | (p[0] & ci);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
   assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & ci);

   assign s  = p ^ c;
   assign c3 = c[3];
endmodule

// File: rtl/n_adder.sv
// rtl/n_adder.sv - N-bit adder with carry-in, registered sum, carry and signed-overflow flags
module n_adder
   import adder_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] in1,
   input  logic [N-1:0] in2,
   input  logic         Cin,
   output logic [N-1:0] result,
   output logic         Cout,
   output logic         Vout
);
   localparam int NG = (N + GW - 1) / GW;
   localparam int NW = NG * GW;

   // Operands zero-extended so the unused top lanes see p = 0 and g = 0.
   logic [NW-1:0] a_pad;
   logic [NW-1:0] b_pad;
   logic [NW-1:0] s_pad;
   logic [NG:0]   gc;
   logic [NG-1:0] c3g;
   logic [NW:0]   sum_ext;
   logic          c_msb;
   logic          cout_d;
   logic          vout_d;
   logic          unused_bits;

   assign a_pad = NW'(in1);
   assign b_pad = NW'(in2);
   assign gc[0] = Cin;

   for (genvar i = 0; i < NG; i++) begin : g_grp
      cla4 u_cla4 (
         .a  (a_pad[i*GW +: GW]),
         .b  (b_pad[i*GW +: GW]),
         .ci (gc[i]),
         .s  (s_pad[i*GW +: GW]),
         .co (gc[i+1]),
         .c3 (c3g[i])
      );
   end

   // With zero-tied upper lanes, the carry out of bit N-1 lands in sum bit N.
   assign sum_ext = {gc[NG], s_pad};
   assign cout_d  = sum_ext[N];

   if (N % GW == 0) begin : g_msb_full
      assign c_msb = c3g[NG-1];
   end else begin : g_msb_part
      assign c_msb = in1[N-1] ^ in2[N-1] ^ sum_ext[N-1];
   end

   assign vout_d      = c_msb ^ cout_d;
   assign unused_bits = ^{c3g, sum_ext};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
         Cout   <= 1'b0;
         Vout   <= 1'b0;
      end else begin
         result <= sum_ext[N-1:0];
         Cout   <= cout_d;
         Vout   <= vout_d;
      end
   end
endmodule

// File: tb/tb_n_adder.sv
// tb/tb_n_adder.sv - self-checking bench for n_adder at N = 32 and N = 8
module tb_n_adder;
   logic        clk;
   logic        rst;
   logic [31:0] a32, b32;
   logic        ci32;
   logic [31:0] r32;
   logic        c32, v32;
   logic [7:0]  a8, b8;
   logic        ci8;
   logic [7:0]  r8;
   logic        c8, v8;

   int total = 0;
   int bad   = 0;

   n_adder #(.N(32)) dut32 (
      .clk(clk), .rst(rst), .in1(a32), .in2(b32), .Cin(ci32),
      .result(r32), .Cout(c32), .Vout(v32)
   );

   n_adder #(.N(8)) dut8 (
      .clk(clk), .rst(rst), .in1(a8), .in2(b8), .Cin(ci8),
      .result(r8), .Cout(c8), .Vout(v8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: wide integer arithmetic, flags from the sign rule.
   function automatic void model(input int n, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, output logic [31:0] r, output logic c,
                                 output logic v);
      longint unsigned mask, s;
      mask = (64'd1 << n) - 64'd1;
      s    = (longint'(a) & mask) + (longint'(b) & mask) + longint'(ci);
      r    = 32'(s & mask);
      c    = s[n];
      v    = (a[n-1] == b[n-1]) && (r[n-1] != a[n-1]);
   endfunction

   task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic ci);
      @(negedge clk);
      a32 = a; b32 = b; ci32 = ci;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(negedge clk);
      a32 = 32'h1234_5678; b32 = 32'h0F0F_0F0F; ci32 = 1'b1;
      a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if ({r32, c32, v32} !== 34'd0) begin
         bad++; $display("FAIL reset32 got=%h want=0", {r32, c32, v32});
      end
      total++;
      if ({r8, c8, v8} !== 10'd0) begin
         bad++; $display("FAIL reset8 got=%h want=0", {r8, c8, v8});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed32;
      logic [31:0] ta [9] = '{32'd2, 32'd1, 32'd14, 32'd15, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                              32'h8000_0000, 32'hFFFF_FFFF, 32'd5};
      logic [31:0] tb [9] = '{32'd3, 32'd3, 32'd1, 32'd1, 32'd1, 32'd1,
                              32'h8000_0000, 32'd0, ~32'd3};
      logic        tc [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
      logic [31:0] er [9] = '{32'd5, 32'd4, 32'd15, 32'd16, 32'h8000_0000, 32'd0,
                              32'd0, 32'd0, 32'd2};
      logic        ec [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
      logic        ev [9] = '{0, 0, 0, 0, 1, 0, 1, 0, 0};
      for (int i = 0; i < 9; i++) begin
         drive32(ta[i], tb[i], tc[i]);
         total++;
         if ({r32, c32, v32} !== {er[i], ec[i], ev[i]}) begin
            bad++;
            $display("FAIL directed32[%0d] got r=%h c=%b v=%b want r=%h c=%b v=%b",
                     i, r32, c32, v32, er[i], ec[i], ev[i]);
         end
      end
   endtask

   task automatic test_random32;
      logic [31:0] a, b, er;
      logic        ci, ec, ev;
      for (int i = 0; i < 40; i++) begin
         a  = $urandom;
         b  = (i % 4 == 0) ? ~a : $urandom;
         ci = 1'($urandom);
         model(32, a, b, ci, er, ec, ev);
         drive32(a, b, ci);
         total++;
         if ({r32, c32, v32} !== {er, ec, ev}) begin
            bad++;
            $display("FAIL random32 a=%h b=%h ci=%b got r=%h c=%b v=%b want r=%h c=%b v=%b",
                     a, b, ci, r32, c32, v32, er, ec, ev);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] a, b, er, pr;
      logic        ci, ec, ev, pc, pv;
      model(32, a32, b32, ci32, pr, pc, pv);
      for (int i = 0; i < 20; i++) begin
         a  = $urandom;
         b  = $urandom;
         ci = 1'($urandom);
         model(32, a, b, ci, er, ec, ev);
         @(negedge clk);
         a32 = a; b32 = b; ci32 = ci;
         #1;
         total++;
         if ({r32, c32, v32} !== {pr, pc, pv}) begin
            bad++;
            $display("FAIL b2b_hold[%0d] got r=%h c=%b v=%b want r=%h c=%b v=%b",
                     i, r32, c32, v32, pr, pc, pv);
         end
         @(posedge clk);
         #1;
         total++;
         if ({r32, c32, v32} !== {er, ec, ev}) begin
            bad++;
            $display("FAIL b2b_next[%0d] got r=%h c=%b v=%b want r=%h c=%b v=%b",
                     i, r32, c32, v32, er, ec, ev);
         end
         pr = er; pc = ec; pv = ev;
      end
   endtask

   task automatic test_async_reset;
      logic [31:0] er;
      logic        ec, ev;
      drive32(32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      total++;
      if ({r32, c32, v32} !== 34'd0) begin
         bad++; $display("FAIL async_assert got=%h want=0", {r32, c32, v32});
      end
      @(posedge clk);
      #1;
      total++;
      if ({r32, c32, v32} !== 34'd0) begin
         bad++; $display("FAIL async_hold got=%h want=0", {r32, c32, v32});
      end
      @(negedge clk);
      rst = 1'b0;
      a32 = 32'h7FFF_FFFF; b32 = 32'd1; ci32 = 1'b0;
      #1;
      total++;
      if ({r32, c32, v32} !== 34'd0) begin
         bad++; $display("FAIL async_release got=%h want=0", {r32, c32, v32});
      end
      model(32, a32, b32, ci32, er, ec, ev);
      @(posedge clk);
      #1;
      total++;
      if ({r32, c32, v32} !== {er, ec, ev}) begin
         bad++;
         $display("FAIL async_first got r=%h c=%b v=%b want r=%h c=%b v=%b",
                  r32, c32, v32, er, ec, ev);
      end
   endtask

   task automatic test_n8;
      logic [31:0] er;
      logic        ec, ev;
      logic [7:0]  a, b;
      logic        ci;
      @(negedge clk);
      a8 = 8'd127; b8 = 8'd1; ci8 = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if ({r8, c8, v8} !== {8'h80, 1'b0, 1'b1}) begin
         bad++; $display("FAIL n8_127p1 got r=%h c=%b v=%b want r=80 c=0 v=1", r8, c8, v8);
      end
      for (int i = 0; i < 30; i++) begin
         a  = 8'($urandom);
         b  = 8'($urandom);
         ci = 1'($urandom);
         model(8, {24'd0, a}, {24'd0, b}, ci, er, ec, ev);
         @(negedge clk);
         a8 = a; b8 = b; ci8 = ci;
         @(posedge clk);
         #1;
         total++;
         if ({r8, c8, v8} !== {er[7:0], ec, ev}) begin
            bad++;
            $display("FAIL n8_random a=%h b=%h ci=%b got r=%h c=%b v=%b want r=%h c=%b v=%b",
                     a, b, ci, r8, c8, v8, er[7:0], ec, ev);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      a32 = '0; b32 = '0; ci32 = 1'b0;
      a8 = '0; b8 = '0; ci8 = 1'b0;
      test_reset();
      test_directed32();
      test_random32();
      test_back_to_back();
      test_async_reset();
      test_n8();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
